// File: rtl/cmp_pkg.sv
// Shared definitions for the frame min/max tracker: FSM encoding and default sizes.
package cmp_pkg;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_FRAME_LEN = 8;

endpackage

// File: rtl/frame_min_max_if.sv
// Sample input stream and frame result output stream of frame_min_max.
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// valid never waits on ready, and the producer holds data stable while valid is high.
interface frame_min_max_if #(
  parameter int WIDTH = cmp_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic             out_all_equal;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_all_equal
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_max, out_all_equal
  );

endinterface

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator: flags a < b, a == b and a > b.
module mag_cmp #(
  parameter int WIDTH = cmp_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  assign less    = (a < b);
  assign equal   = (a == b);
  assign greater = (a > b);

endmodule

// File: rtl/frame_min_max.sv
// Tracks running min/max over frames of FRAME_LEN unsigned samples and presents
// one registered result per frame, held until the downstream consumes it.
module frame_min_max
  import cmp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  localparam int CW       = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  frame_min_max_if.slave      bus,
  output state_t              dbg_state,
  output logic [CW-1:0]       dbg_cnt
);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] cur_min;
  logic [WIDTH-1:0] cur_max;
  logic [WIDTH-1:0] nxt_min;
  logic [WIDTH-1:0] nxt_max;
  logic             lt_min;
  logic             gt_max;
  logic             min_eq_unused;
  logic             min_gt_unused;
  logic             max_lt_unused;
  logic             max_eq_unused;
  logic             accept;
  logic             last;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a       (bus.in_data),
    .b       (cur_min),
    .less    (lt_min),
    .equal   (min_eq_unused),
    .greater (min_gt_unused)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a       (bus.in_data),
    .b       (cur_max),
    .less    (max_lt_unused),
    .equal   (max_eq_unused),
    .greater (gt_max)
  );

  assign bus.in_ready = (state != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;
  // Ties against either bound keep the current value.
  assign nxt_min      = lt_min ? bus.in_data : cur_min;
  assign nxt_max      = gt_max ? bus.in_data : cur_max;
  assign last         = (cnt == CW'(FRAME_LEN - 1));

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= FIRST;
      cnt               <= '0;
      cur_min           <= '0;
      cur_max           <= '0;
      bus.out_min       <= '0;
      bus.out_max       <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_all_equal <= 1'b0;
    end else begin
      case (state)
        FIRST: begin
          if (accept) begin
            cur_min <= bus.in_data;
            cur_max <= bus.in_data;
            cnt     <= CW'(1);
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cur_min <= nxt_min;
            cur_max <= nxt_max;
            if (last) begin
              bus.out_min       <= nxt_min;
              bus.out_max       <= nxt_max;
              bus.out_all_equal <= (nxt_min == nxt_max);
              bus.out_valid     <= 1'b1;
              cnt               <= '0;
              state             <= HOLD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          // Result fields stay as they are after the consume; out_valid qualifies them.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= FIRST;
          end
        end
        default: begin
          state <= FIRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_min_max.sv
// Directed bench for frame_min_max: a frame vector table plus hold, gap, reset and spacing sequences.
module tb_frame_min_max;
  import cmp_pkg::*;

  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = 8;
  localparam int CW        = $clog2(FRAME_LEN);

  logic          clk;
  logic          rst_n;
  state_t        dbg_state;
  logic [CW-1:0] dbg_cnt;
  int            vec_cnt  = 0;
  int            miss_cnt = 0;
  int            cyc      = 0;

  frame_min_max_if #(.WIDTH(WIDTH)) bus ();

  frame_min_max #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // frame table: samples packed first-sample-in-top-nibble
  typedef struct packed {
    logic [31:0]      s;
    logic [WIDTH-1:0] emin;
    logic [WIDTH-1:0] emax;
    logic             eeq;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: present one sample and hold it until accepted (bounded wait)
  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] emin,
                              input logic [WIDTH-1:0] emax, input logic eeq);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_min"},   32'(bus.out_min), 32'(emin));
    check({tag, "_max"},   32'(bus.out_max), 32'(emax));
    check({tag, "_eq"},    32'(bus.out_all_equal), 32'(eeq));
    check({tag, "_rdy0"},  32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    int t1;
    int t2;

    vecs[0] = '{s: 32'h39174C05, emin: 4'd0,  emax: 4'd12, eeq: 1'b0};
    vecs[1] = '{s: 32'h66666666, emin: 4'd6,  emax: 4'd6,  eeq: 1'b1};
    vecs[2] = '{s: 32'h12345678, emin: 4'd1,  emax: 4'd8,  eeq: 1'b0};
    vecs[3] = '{s: 32'h87654321, emin: 4'd1,  emax: 4'd8,  eeq: 1'b0};
    vecs[4] = '{s: 32'hF0F0F0F0, emin: 4'd0,  emax: 4'd15, eeq: 1'b0};
    vecs[5] = '{s: 32'h0000000F, emin: 4'd0,  emax: 4'd15, eeq: 1'b0};
    vecs[6] = '{s: 32'hFFFFFFFF, emin: 4'd15, emax: 4'd15, eeq: 1'b1};
    vecs[7] = '{s: 32'h00000000, emin: 4'd0,  emax: 4'd0,  eeq: 1'b1};
    vecs[8] = '{s: 32'h77777778, emin: 4'd7,  emax: 4'd8,  eeq: 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_min",   32'(bus.out_min), 32'd0);
    check("rst_max",   32'(bus.out_max), 32'd0);
    check("rst_eq",    32'(bus.out_all_equal), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(FIRST));
    check("rst_cnt",   32'(dbg_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // table-driven frames, back-to-back samples, out_ready high
    for (int v = 0; v < 9; v++) begin
      logic [31:0] s;
      s = vecs[v].s;
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (i == FRAME_LEN - 1) check("early_valid", 32'(bus.out_valid), 32'd0);
        send(s[31 - 4*i -: 4]);
      end
      check_result($sformatf("vec%0d", v), vecs[v].emin, vecs[v].emax, vecs[v].eeq);
      tick();
      check("consumed_valid", 32'(bus.out_valid), 32'd0);
      check("consumed_ready", 32'(bus.in_ready), 32'd1);
    end

    // result held while out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) send((i % 2 == 0) ? 4'd15 : 4'd0);
    for (int k = 0; k < 5; k++) begin
      check_result("hold", 4'd0, 4'd15, 1'b0);
      check("hold_state", 32'(dbg_state), 32'(HOLD));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("hold_release_valid", 32'(bus.out_valid), 32'd0);
    check("hold_release_ready", 32'(bus.in_ready), 32'd1);
    check("hold_keep_min", 32'(bus.out_min), 32'd0);
    check("hold_keep_max", 32'(bus.out_max), 32'd15);
    gap(2);
    check("idle_ready_no_effect", 32'(bus.out_valid), 32'd0);

    // bubbles of 0..3 cycles between samples
    for (int i = 0; i < FRAME_LEN; i++) begin
      gap($urandom_range(0, 3));
      send(4'd5);
      check($sformatf("gap_cnt%0d", i), 32'(dbg_cnt), 32'((i + 1) % FRAME_LEN));
    end
    check_result("gap", 4'd5, 4'd5, 1'b1);
    tick();

    // reset mid-frame discards the partial frame
    send(4'd2); send(4'd8); send(4'd3); send(4'd1);
    check("abort_no_valid", 32'(bus.out_valid), 32'd0);
    check("abort_cnt", 32'(dbg_cnt), 32'd4);
    rst_n = 1'b0;
    #3;
    check("abort_state", 32'(dbg_state), 32'(FIRST));
    check("abort_cnt_rst", 32'(dbg_cnt), 32'd0);
    check("abort_min_rst", 32'(bus.out_min), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == FRAME_LEN - 1) check("abort_early_valid", 32'(bus.out_valid), 32'd0);
      send(4'(4 + i));
    end
    check_result("after_rst", 4'd4, 4'd11, 1'b0);
    tick();

    // two frames back-to-back: result spacing is FRAME_LEN+1 cycles
    for (int i = 0; i < FRAME_LEN; i++) send(4'(1 + i));
    t1 = cyc;
    check_result("b2b_a", 4'd1, 4'd8, 1'b0);
    for (int i = 0; i < FRAME_LEN; i++) send(4'(8 - i));
    t2 = cyc;
    check_result("b2b_b", 4'd1, 4'd8, 1'b0);
    check("b2b_spacing", 32'(t2 - t1), 32'(FRAME_LEN + 1));
    tick();
    check("b2b_done_valid", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
